// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard event decoder.
package kbd_pkg;

  localparam int unsigned CODE_W = 8;
  localparam int unsigned KEY_W  = 9;
  localparam int unsigned EVT_W  = 10;

  localparam logic [CODE_W-1:0] PS2_EXT = 8'hE0;
  localparam logic [CODE_W-1:0] PS2_BRK = 8'hF0;

  // Byte-handshake FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_DEC  = 2'd2
  } kbd_state_t;

  // Event record, MSB first: {ext, brk, code}
  typedef struct packed {
    logic              ext;
    logic              brk;
    logic [CODE_W-1:0] code;
  } kbd_evt_t;

  // Key identity used for repeat and release matching: {ext, code}
  function automatic logic [KEY_W-1:0] key_of(input kbd_evt_t evt);
    return {evt.ext, evt.code};
  endfunction

  // Prefix bytes modify the next event rather than producing one
  function automatic logic is_prefix(input logic [CODE_W-1:0] b);
    return (b == PS2_EXT) || (b == PS2_BRK);
  endfunction

endpackage

// File: rtl/kbd_evt_fifo.sv
// Small synchronous FIFO holding decoded key events; head is visible combinationally.
module kbd_evt_fifo
  import kbd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     resetn,
  input  logic     push,
  input  kbd_evt_t push_data,
  input  logic     pop,
  output kbd_evt_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  kbd_evt_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_pop;
  logic            do_push;

  // Status and effective handshakes; a pop frees the slot a same-cycle push needs
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    pop_data = mem[rd_ptr[AW-1:0]];
  end

  // Storage array, no reset needed since empty masks stale entries
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Read and write pointers with wrap bit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/kbd_event_decoder.sv
// Turns raw PS/2 scancode bytes into make/break events, tracks the held key and counts presses.
module kbd_event_decoder
  import kbd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned SUPPRESS_RPT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [CODE_W-1:0] ps2_data,
  input  logic              ps2_ready,
  input  logic              ps2_overflow,
  output logic              ps2_nextdata_n,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [CODE_W-1:0] ev_code,
  output logic              ev_ext,
  output logic              ev_brk,
  output logic              key_down,
  output logic [KEY_W-1:0]  last_code,
  output logic [CNT_W-1:0]  press_cnt,
  output logic              drop_err,
  output logic              ovf_err
);

  kbd_state_t        state;
  logic              run_q;
  logic [CODE_W-1:0] byte_q;
  logic              ext_pend;
  logic              brk_pend;

  kbd_evt_t          evt_c;
  kbd_evt_t          head_c;
  logic              in_dec_c;
  logic              ev_byte_c;
  logic              match_c;
  logic              repeat_c;
  logic              push_c;
  logic              count_c;
  logic              release_c;
  logic              pop_c;
  logic              drop_c;
  logic              fifo_full;
  logic              fifo_empty;

  // Reset-release synchroniser: FSM may start sampling on the second edge after deassertion
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Byte handshake FSM: latch byte, pop it from the keyboard FIFO, then decode
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      ps2_nextdata_n <= 1'b1;
      byte_q         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ps2_nextdata_n <= 1'b1;
          if (run_q && ps2_ready) begin
            byte_q         <= ps2_data;
            state          <= ST_ACK;
            ps2_nextdata_n <= 1'b0;
          end
        end
        ST_ACK: begin
          state          <= ST_DEC;
          ps2_nextdata_n <= 1'b1;
        end
        ST_DEC: begin
          state          <= ST_IDLE;
          ps2_nextdata_n <= 1'b1;
        end
        default: begin
          state          <= ST_IDLE;
          ps2_nextdata_n <= 1'b1;
        end
      endcase
    end
  end

  // Event classification for the byte being decoded
  always_comb begin
    in_dec_c  = (state == ST_DEC);
    evt_c     = '{ext: ext_pend, brk: brk_pend, code: byte_q};
    match_c   = (key_of(evt_c) == last_code);
    ev_byte_c = in_dec_c && !is_prefix(byte_q);
    repeat_c  = ev_byte_c && !brk_pend && key_down && match_c;
    count_c   = ev_byte_c && !brk_pend && !repeat_c;
    release_c = ev_byte_c && brk_pend && match_c;
    push_c    = ev_byte_c && (brk_pend || !repeat_c || (SUPPRESS_RPT == 0));
    pop_c     = ev_ready && !fifo_empty;
    drop_c    = push_c && fifo_full && !pop_c;
  end

  // Prefix flags collect E0/F0 and are consumed by the next real scancode
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (in_dec_c) begin
      if (byte_q == PS2_EXT) begin
        ext_pend <= 1'b1;
      end else if (byte_q == PS2_BRK) begin
        brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

  // Held-key tracking and press counter; updates even if the event itself is dropped
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_down  <= 1'b0;
      last_code <= '0;
      press_cnt <= '0;
    end else begin
      if (count_c) begin
        key_down  <= 1'b1;
        last_code <= key_of(evt_c);
        press_cnt <= press_cnt + CNT_W'(1);
      end else if (release_c) begin
        key_down  <= 1'b0;
      end
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_err <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      if (drop_c) begin
        drop_err <= 1'b1;
      end
      if (ps2_overflow) begin
        ovf_err <= 1'b1;
      end
    end
  end

  kbd_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push_c),
    .push_data (evt_c),
    .pop       (pop_c),
    .pop_data  (head_c),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Consumer-facing view of the FIFO head
  always_comb begin
    ev_valid = !fifo_empty;
    ev_code  = head_c.code;
    ev_ext   = head_c.ext;
    ev_brk   = head_c.brk;
  end

endmodule

// File: tb/tb_kbd_event_decoder.sv
// Bench for kbd_event_decoder: two configurations driven by one PS/2 byte stream,
// each compared against a queue-based behavioural model of the decoding rules.
module tb_kbd_event_decoder;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_ready = 1'b0;
  logic       ps2_overflow = 1'b0;
  logic       ev_ready = 1'b0;

  logic       nd0, v0, ext0, brk0, kd0, de0, oe0;
  logic [7:0] code0, pc0;
  logic [8:0] lc0;
  logic       nd1, v1, ext1, brk1, kd1, de1, oe1;
  logic [7:0] code1;
  logic [3:0] pc1;
  logic [8:0] lc1;

  int checks = 0;
  int failures = 0;
  int ack_lat = 2;

  logic [9:0] q0[$];
  logic [9:0] q1[$];
  bit         m_ext[2], m_brk[2], m_kd[2], m_drop[2], m_ovf[2];
  logic [8:0] m_lc[2];
  int         m_cnt[2];

  kbd_event_decoder #(.FIFO_DEPTH(4), .CNT_W(8), .SUPPRESS_RPT(1)) dut0 (
    .clk(clk), .resetn(resetn), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
    .ps2_overflow(ps2_overflow), .ps2_nextdata_n(nd0), .ev_valid(v0), .ev_ready(ev_ready),
    .ev_code(code0), .ev_ext(ext0), .ev_brk(brk0), .key_down(kd0), .last_code(lc0),
    .press_cnt(pc0), .drop_err(de0), .ovf_err(oe0));

  kbd_event_decoder #(.FIFO_DEPTH(8), .CNT_W(4), .SUPPRESS_RPT(0)) dut1 (
    .clk(clk), .resetn(resetn), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
    .ps2_overflow(ps2_overflow), .ps2_nextdata_n(nd1), .ev_valid(v1), .ev_ready(ev_ready),
    .ev_code(code1), .ev_ext(ext1), .ev_brk(brk1), .key_down(kd1), .last_code(lc1),
    .press_cnt(pc1), .drop_err(de1), .ovf_err(oe1));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic int dep(input int i);  return (i == 0) ? 4 : 8;    endfunction
  function automatic bit sup(input int i);  return (i == 0);            endfunction
  function automatic int cmod(input int i); return (i == 0) ? 256 : 16; endfunction
  function automatic int qsize(input int i); return (i == 0) ? q0.size() : q1.size(); endfunction
  function automatic logic [9:0] qhead(input int i); return (i == 0) ? q0[0] : q1[0]; endfunction

  task automatic m_push(input int i, input logic [9:0] e);
    if (qsize(i) < dep(i)) begin
      if (i == 0) q0.push_back(e); else q1.push_back(e);
    end else begin
      m_drop[i] = 1'b1;
    end
  endtask

  task automatic m_pop(input int i);
    if (qsize(i) > 0) begin
      if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
  endtask

  task automatic m_reset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      m_ext[i] = 0; m_brk[i] = 0; m_kd[i] = 0; m_drop[i] = 0; m_ovf[i] = 0;
      m_lc[i] = 9'h000; m_cnt[i] = 0;
    end
  endtask

  task automatic model_byte(input int i, input logic [7:0] b, input bit pop);
    logic [8:0] key;
    logic [9:0] ev;
    if (pop) m_pop(i);
    if (b == 8'hE0) m_ext[i] = 1'b1;
    else if (b == 8'hF0) m_brk[i] = 1'b1;
    else begin
      key = {m_ext[i], b};
      ev  = {m_ext[i], m_brk[i], b};
      if (m_brk[i]) begin
        m_push(i, ev);
        if (key == m_lc[i]) m_kd[i] = 1'b0;
      end else if (m_kd[i] && key == m_lc[i]) begin
        if (!sup(i)) m_push(i, ev);
      end else begin
        m_push(i, ev);
        m_kd[i] = 1'b1;
        m_lc[i] = key;
        m_cnt[i] = (m_cnt[i] + 1) % cmod(i);
      end
      m_ext[i] = 1'b0;
      m_brk[i] = 1'b0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input int i, input logic v, input logic [9:0] h);
    chk($sformatf("d%0d_ev_valid", i), 32'(v), 32'(qsize(i) > 0));
    if (qsize(i) > 0) chk($sformatf("d%0d_ev_head", i), 32'(h), 32'(qhead(i)));
  endtask

  task automatic chk_dut(input int i, input logic v, input logic [9:0] h, input logic kd,
                         input logic [8:0] lc, input int pc, input logic de, input logic oe);
    chk_head(i, v, h);
    chk($sformatf("d%0d_key_down", i), 32'(kd), 32'(m_kd[i]));
    chk($sformatf("d%0d_last_code", i), 32'(lc), 32'(m_lc[i]));
    chk($sformatf("d%0d_press_cnt", i), 32'(pc), 32'(m_cnt[i]));
    chk($sformatf("d%0d_drop_err", i), 32'(de), 32'(m_drop[i]));
    chk($sformatf("d%0d_ovf_err", i), 32'(oe), 32'(m_ovf[i]));
  endtask

  task automatic check_all();
    chk_dut(0, v0, {ext0, brk0, code0}, kd0, lc0, int'(pc0), de0, oe0);
    chk_dut(1, v1, {ext1, brk1, code1}, kd1, lc1, int'(pc1), de1, oe1);
  endtask

  task automatic check_heads();
    chk_head(0, v0, {ext0, brk0, code0});
    chk_head(1, v1, {ext1, brk1, code1});
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic start_ack(input logic [7:0] b, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    ps2_data = b;
    ps2_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      n++;
      if (nd0 === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ack_latency", 32'(n), 32'(ack_lat));
    if (ok) chk("d1_ack_pop", 32'(nd1), 32'd0);
    ps2_ready = 1'b0;
    ack_lat = 1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit pop_dec);
    bit ok;
    start_ack(b, ok);
    if (!ok) return;
    @(posedge clk); @(negedge clk);
    chk("pop_strobe_released", 32'(nd0), 32'd1);
    check_heads();
    if (pop_dec) ev_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    ev_ready = 1'b0;
    chk("idle_no_pop", 32'(nd0), 32'd1);
    model_byte(0, b, pop_dec);
    model_byte(1, b, pop_dec);
    check_all();
  endtask

  task automatic drain(input int k);
    for (int j = 0; j < k; j++) begin
      check_heads();
      ev_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      ev_ready = 1'b0;
      m_pop(0);
      m_pop(1);
    end
    check_all();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    ps2_ready = 1'b0;
    ev_ready = 1'b0;
    m_reset();
    #1;
    chk("rst_nextdata_n0", 32'(nd0), 32'd1);
    chk("rst_nextdata_n1", 32'(nd1), 32'd1);
    check_all();
    @(posedge clk); @(negedge clk);
    resetn = 1'b1;
    ack_lat = 2;
  endtask

  task automatic pulse_ovf();
    ps2_overflow = 1'b1;
    @(posedge clk); @(negedge clk);
    ps2_overflow = 1'b0;
    m_ovf[0] = 1'b1;
    m_ovf[1] = 1'b1;
    check_all();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] codes [4];
    logic [7:0] b;
    int r;
    codes[0] = 8'h15; codes[1] = 8'h1C; codes[2] = 8'h23; codes[3] = 8'h75;

    m_reset();
    @(negedge clk);
    do_reset();

    // single make, then its release
    send_byte(8'h15, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h15, 1'b0);
    drain(2);

    // extended make and extended release
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    chk("ext_last_code", 32'(lc0), 32'h175);
    drain(2);

    // typematic repeat of one key
    send_byte(8'h1C, 1'b0);
    send_byte(8'h1C, 1'b0);
    send_byte(8'h1C, 1'b0);
    drain(4);

    // overfill with six distinct makes, then drain past empty
    send_byte(8'h21, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h24, 1'b0);
    send_byte(8'h26, 1'b0);
    send_byte(8'h2A, 1'b0);
    send_byte(8'h2B, 1'b0);
    // push into a full FIFO with a simultaneous pop must be accepted
    send_byte(8'h2C, 1'b1);
    drain(9);

    pulse_ovf();

    // reset during the ACK of a byte abandons it
    begin
      bit ok;
      start_ack(8'h23, ok);
      do_reset();
      repeat (4) @(negedge clk);
      check_all();
      ack_lat = 1;
    end

    // first byte after a fresh release is picked up on the second edge
    do_reset();
    send_byte(8'h29, 1'b0);
    drain(1);

    // randomized byte stream with random consumer activity
    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0) b = 8'hE0;
      else if (r == 1) b = 8'hF0;
      else if (r < 8) b = codes[$urandom_range(0, 3)];
      else b = 8'(($urandom_range(1, 127)));
      send_byte(b, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) == 0) drain($urandom_range(1, 3));
      if (t == 200) pulse_ovf();
    end
    drain(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
